// File: rtl/mem_responder.sv
// Memory-side responder for the datapath MAR/MDR bus: one RAM or I/O access per request,
// WAIT_STATES cycles of added latency, and a single-cycle MEM_R completion strobe.
module mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        MEM_R,
    output logic [15:0] HEX_Data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

    state_t              state, state_next;
    logic [3:0]          cnt;
    logic [15:0]         addr_q;
    logic [15:0]         data_q;
    logic                wr_q;
    logic                start;
    logic                commit;
    logic                is_io;
    logic [ADDR_W-1:0]   idx;
    logic [15:0]         ram [0:(1 << ADDR_W) - 1];

    assign is_io = (addr_q == IO_ADDR);
    assign idx   = addr_q[ADDR_W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                // Conflicting or absent requests are ignored entirely.
                if (MEM_RD ^ MEM_WR) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = (MEM_RD || MEM_WR) ? HOLD : IDLE;
            end
            HOLD: begin
                // Wait out a level request that is still asserted so it cannot start a second access.
                if (!MEM_RD && !MEM_WR) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= 4'd0;
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            wr_q     <= 1'b0;
            MDR_In   <= 16'h0000;
            HEX_Data <= 16'h0000;
            MEM_R    <= 1'b0;
        end else begin
            if (start) begin
                addr_q <= MAR;
                data_q <= MDR;
                wr_q   <= MEM_WR;
                cnt    <= WAIT_STATES[3:0];
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (commit && !wr_q) MDR_In <= is_io ? Switches : ram[idx];
            if (commit && wr_q && is_io) HEX_Data <= data_q;

            // Registered decode of the RESP state keeps the strobe glitch-free.
            MEM_R <= (state_next == RESP);
        end
    end

    // NOTE: the RAM array has no reset; contents survive Reset and only the control path is cleared.
    always_ff @(posedge Clk) begin
        if (commit && wr_q && !is_io) ram[idx] <= data_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level reference model plus directed
// and randomized requests, and a second zero-wait-state instance for capture/aliasing.
module tb_mem_responder;

    localparam int          W  = 2;
    localparam logic [15:0] IO = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] MAR, MDR, Switches;
    logic        MEM_RD, MEM_WR;
    logic [15:0] MDR_In, HEX_Data;
    logic        MEM_R;

    logic [15:0] mar0, mdr0, mdr_in0, hex0;
    logic        rd0, wr0, mem_r0;

    mem_responder #(.ADDR_W(10), .WAIT_STATES(W), .IO_ADDR(IO)) dut (
        .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .Switches(Switches), .MDR_In(MDR_In), .MEM_R(MEM_R), .HEX_Data(HEX_Data)
    );

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(IO)) dut0 (
        .Clk(Clk), .Reset(Reset), .MAR(mar0), .MDR(mdr0), .MEM_RD(rd0), .MEM_WR(wr0),
        .Switches(Switches), .MDR_In(mdr_in0), .MEM_R(mem_r0), .HEX_Data(hex0)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model: word contents, known-ness, expected outputs, and the one pending commit.
    logic [15:0] m_mem [0:1023];
    bit          m_val [0:1023];
    logic [15:0] exp_mdr, exp_hex;
    bit          mdr_known;
    bit          sched_valid;
    int          sched_cyc;
    bit          sched_wr;
    logic [15:0] sched_addr, sched_data;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            bit exp_mr;
            int idx;
            @(negedge Clk);
            exp_mr = 1'b0;
            if (Reset) begin
                exp_mdr   = 16'h0000;
                exp_hex   = 16'h0000;
                mdr_known = 1'b1;
            end else if (sched_valid && cyc == sched_cyc) begin
                exp_mr = 1'b1;
                idx    = int'(sched_addr[9:0]);
                if (sched_wr) begin
                    if (sched_addr == IO) exp_hex = sched_data;
                    else begin
                        m_mem[idx] = sched_data;
                        m_val[idx] = 1'b1;
                    end
                end else if (sched_addr == IO) begin
                    exp_mdr   = Switches;
                    mdr_known = 1'b1;
                end else begin
                    exp_mdr   = m_mem[idx];
                    mdr_known = m_val[idx];
                end
            end
            check("mem_r", {15'd0, MEM_R}, {15'd0, exp_mr});
            check("hex_data", HEX_Data, exp_hex);
            if (mdr_known) check("mdr_in", MDR_In, exp_mdr);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One request held until MEM_R plus 'hold' extra cycles; reports edges to MEM_R and pulses seen.
    task automatic access(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data,
                          input int hold, output int lat, output int pulses);
        MAR         = addr;
        MDR         = data;
        MEM_RD      = rd;
        MEM_WR      = wr;
        sched_wr    = wr;
        sched_addr  = addr;
        sched_data  = data;
        sched_cyc   = cyc + W + 2;
        sched_valid = 1'b1;
        step();
        MAR    = 16'($urandom);
        MDR    = 16'($urandom);
        lat    = 0;
        pulses = 0;
        while (!MEM_R && lat < 20) begin
            step();
            lat++;
        end
        if (!MEM_R) begin
            checks++;
            errors++;
            $display("FAIL mem_r_timeout: no MEM_R within %0d edges of request to %h", lat, addr);
        end else begin
            pulses = 1;
        end
        repeat (hold) begin
            step();
            if (MEM_R) pulses++;
        end
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
        step();
        if (MEM_R) pulses++;
    endtask

    task automatic both_high(input int n);
        MEM_RD = 1'b1;
        MEM_WR = 1'b1;
        MAR    = 16'($urandom);
        MDR    = 16'($urandom);
        repeat (n) step();
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
        step();
    endtask

    initial begin
        int lat, pulses;
        logic [31:0] r, ra;
        logic [15:0] addr;

        Reset = 1'b1;
        MAR = 16'h0; MDR = 16'h0; MEM_RD = 1'b0; MEM_WR = 1'b0; Switches = 16'h0;
        mar0 = 16'h0; mdr0 = 16'h0; rd0 = 1'b0; wr0 = 1'b0;
        exp_mdr = 16'h0; exp_hex = 16'h0; mdr_known = 1'b1; sched_valid = 1'b0;
        sched_cyc = -1; sched_wr = 1'b0; sched_addr = 16'h0; sched_data = 16'h0;
        for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;

        fork
            compare_loop();
        join_none

        repeat (2) step();
        check("reset_mdr_in", MDR_In, 16'h0000);
        check("reset_mem_r", {15'd0, MEM_R}, 16'h0000);
        check("reset_hex", HEX_Data, 16'h0000);
        Reset = 1'b0;
        step();

        // Write then read back, three edges from request to MEM_R each time.
        access(1'b0, 1'b1, 16'h0123, 16'hBEEF, 0, lat, pulses);
        check("t1_wr_latency", 16'(lat), 16'd3);
        access(1'b1, 1'b0, 16'h0123, 16'h0000, 0, lat, pulses);
        check("t1_rd_latency", 16'(lat), 16'd3);
        check("t1_rd_data", MDR_In, 16'hBEEF);

        // I/O port: switches on read, hex register on write, RAM[0x3FF] untouched.
        Switches = 16'hA5A5;
        access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, lat, pulses);
        check("t2_switches", MDR_In, 16'hA5A5);
        access(1'b0, 1'b1, 16'h03FF, 16'h3FF0, 0, lat, pulses);
        access(1'b0, 1'b1, 16'hFFFF, 16'h1234, 0, lat, pulses);
        check("t2_hex", HEX_Data, 16'h1234);
        access(1'b1, 1'b0, 16'h03FF, 16'h0000, 0, lat, pulses);
        check("t2_ram_3ff", MDR_In, 16'h3FF0);

        // Read held high well past completion: exactly one strobe.
        access(1'b1, 1'b0, 16'h0123, 16'h0000, 7, lat, pulses);
        check("t3_pulses", 16'(pulses), 16'd1);
        check("t3_data", MDR_In, 16'hBEEF);

        // Conflicting requests do nothing.
        both_high(5);
        check("t4_mdr_unchanged", MDR_In, 16'hBEEF);
        access(1'b1, 1'b0, 16'h03FF, 16'h0000, 0, lat, pulses);
        check("t4_ram_unchanged", MDR_In, 16'h3FF0);

        // Reset one cycle into a write aborts it.
        access(1'b0, 1'b1, 16'h0010, 16'h1111, 0, lat, pulses);
        sched_valid = 1'b0;
        MAR = 16'h0010; MDR = 16'h5555; MEM_WR = 1'b1;
        step();
        step();
        Reset = 1'b1;
        #1;
        check("t5_mdr_zero", MDR_In, 16'h0000);
        check("t5_hex_zero", HEX_Data, 16'h0000);
        check("t5_mem_r_zero", {15'd0, MEM_R}, 16'h0000);
        MEM_WR = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
        step();
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, lat, pulses);
        check("t5_ram_kept", MDR_In, 16'h1111);

        // Zero-wait instance: MAR change after capture is ignored; 0x0400 aliases 0x0000.
        mar0 = 16'h0400; mdr0 = 16'h7777; wr0 = 1'b1;
        step();
        mar0 = 16'h0222; mdr0 = 16'h0000;
        check("t6_no_early_strobe", {15'd0, mem_r0}, 16'h0000);
        step();
        check("t6_wr_strobe", {15'd0, mem_r0}, 16'h0001);
        wr0 = 1'b0;
        step();
        check("t6_strobe_one_cycle", {15'd0, mem_r0}, 16'h0000);
        mar0 = 16'h0000; rd0 = 1'b1;
        step();
        step();
        check("t6_rd_strobe", {15'd0, mem_r0}, 16'h0001);
        check("t6_alias_data", mdr_in0, 16'h7777);
        rd0 = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            r  = $urandom;
            ra = $urandom;
            if (r[2:0] == 3'd0) begin
                both_high(1 + int'(r[7:6]));
            end else if (r[2:0] == 3'd1) begin
                repeat (1 + int'(r[7:6])) step();
            end else begin
                Switches = 16'($urandom);
                addr = (r[4:3] == 2'd0) ? IO : {ra[15:10], 6'b000000, ra[3:0]};
                access(!r[5], r[5], addr, 16'($urandom), int'(r[9:8]), lat, pulses);
                check("rand_latency", 16'(lat), 16'(W + 1));
                check("rand_pulses", 16'(pulses), 16'd1);
            end
        end

        repeat (2) step();
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
